// File: rtl/i2c_inject_tx.sv
// i2c_inject_tx: open-drain I2C write master that injects START, address+W, data bytes and STOP.
// Optional build macro CLOCK_STRETCH_EN: honour slave clock stretching while SCL is released.
`timescale 1ns/1ps
module i2c_inject_tx #(
    parameter int CLK_DIV = 25
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [6:0] i_dev_addr,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    input  logic       i_tx_last,
    output logic       o_tx_ready,
    input  logic       i_scl_in,
    input  logic       i_sda_in,
    output logic       o_scl_oe,
    output logic       o_sda_oe,
    output logic [8:0] o_stat_word,
    output logic       o_stat_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP,
        S_FREE
    } state_t;

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_div;
    logic [1:0] r_q;
    logic [3:0] r_bit;
    logic [7:0] r_shreg;
    logic [7:0] r_byte;
    logic       r_last;
    logic       r_ack;
    logic       r_nack;
    logic       r_stat_valid;
    logic [8:0] r_stat_word;
    logic       r_done;

    logic w_hold;
    logic w_tick;
    logic w_qend;
    logic w_accept;
    logic w_sample;
    logic w_arb_lost;
    logic w_decide;
    logic w_load;
    logic w_scl_oe;
    logic w_sda_oe;

`ifdef CLOCK_STRETCH_EN
    // The quarter where SCL is released waits until the bus actually shows SCL high.
    assign w_hold = ((r_state == S_BIT) || (r_state == S_STOP)) && (r_q == 2'd2) && !i_scl_in;
`else
    logic w_unused_scl;
    assign w_unused_scl = i_scl_in;
    assign w_hold       = 1'b0;
`endif

    assign w_tick     = (r_div == DIV_MAX) && !w_hold;
    assign w_qend     = w_tick && (r_q == 2'd3);
    assign w_accept   = (r_state == S_IDLE) && i_start;
    assign w_sample   = (r_state == S_BIT) && w_tick && (r_q == 2'd2);
    assign w_arb_lost = w_sample && (r_bit != 4'd8) && r_shreg[7] && !i_sda_in;
    assign w_decide   = (r_state == S_BIT) && w_qend && (r_bit == 4'd8);
    assign w_load     = w_decide && !r_ack && !r_last && i_tx_valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_sda_oe = 1'b1;
                w_scl_oe = r_q[1];
                if (w_qend) begin
                    w_next = S_BIT;
                end
            end
            S_BIT: begin
                w_scl_oe = !r_q[1];
                w_sda_oe = (r_bit == 4'd8) ? 1'b0 : !r_shreg[7];
                // Losing arbitration abandons the bus without a STOP.
                if (w_arb_lost) begin
                    w_next = S_FREE;
                end else if (w_decide && !w_load) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                w_scl_oe = !r_q[1];
                w_sda_oe = (r_q != 2'd3);
                if (w_qend) begin
                    w_next = S_FREE;
                end
            end
            S_FREE: begin
                if (w_qend) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div        <= 8'd0;
            r_q          <= 2'd0;
            r_bit        <= 4'd0;
            r_shreg      <= 8'd0;
            r_byte       <= 8'd0;
            r_last       <= 1'b0;
            r_ack        <= 1'b0;
            r_nack       <= 1'b0;
            r_stat_valid <= 1'b0;
            r_stat_word  <= 9'd0;
            r_done       <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_div <= 8'd0;
                r_q   <= 2'd0;
            end else if (w_tick) begin
                r_div <= 8'd0;
                r_q   <= w_arb_lost ? 2'd0 : r_q + 2'd1;
            end else if (!w_hold) begin
                r_div <= r_div + 8'd1;
            end

            // The address phase reports the bare 7-bit address, as the listener does.
            if (w_accept) begin
                r_shreg <= {i_dev_addr, 1'b0};
                r_byte  <= {1'b0, i_dev_addr};
                r_last  <= 1'b0;
                r_bit   <= 4'd0;
            end else if (w_load) begin
                r_shreg <= i_tx_data;
                r_byte  <= i_tx_data;
                r_last  <= i_tx_last;
                r_bit   <= 4'd0;
            end else if ((r_state == S_BIT) && w_qend && (r_bit != 4'd8)) begin
                r_shreg <= {r_shreg[6:0], 1'b0};
                r_bit   <= r_bit + 4'd1;
            end

            if (w_sample && (r_bit == 4'd8)) begin
                r_ack <= i_sda_in;
            end

            if (w_accept) begin
                r_nack <= 1'b0;
            end else if ((w_decide && r_ack) || w_arb_lost) begin
                r_nack <= 1'b1;
            end

            r_stat_valid <= w_decide;
            if (w_decide) begin
                r_stat_word <= {r_byte, r_ack};
            end
            r_done <= (r_state == S_FREE) && w_qend;
        end
    end

    assign o_tx_ready   = w_load;
    assign o_scl_oe     = w_scl_oe;
    assign o_sda_oe     = w_sda_oe;
    assign o_stat_word  = r_stat_word;
    assign o_stat_valid = r_stat_valid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_nack       = r_nack;

endmodule

// File: tb/tb_i2c_inject_tx.sv
// tb_i2c_inject_tx: directed scenarios for i2c_inject_tx with a small bus/slave model and TX feeder.
`timescale 1ns/1ps
module tb_i2c_inject_tx;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic [8:0] stat_word;
    logic       stat_valid;
    logic       busy;
    logic       done;
    logic       nack;

    logic stretch_hold = 1'b0;
    logic ack_drive = 1'b0;
    logic arb_pull = 1'b0;

    assign scl_in = !scl_oe && !stretch_hold;
    assign sda_in = !sda_oe && !ack_drive && !arb_pull;

    i2c_inject_tx #(.CLK_DIV(CLK_DIV)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_dev_addr  (dev_addr),
        .i_tx_data   (tx_data),
        .i_tx_valid  (tx_valid),
        .i_tx_last   (tx_last),
        .o_tx_ready  (tx_ready),
        .i_scl_in    (scl_in),
        .i_sda_in    (sda_in),
        .o_scl_oe    (scl_oe),
        .o_sda_oe    (sda_oe),
        .o_stat_word (stat_word),
        .o_stat_valid(stat_valid),
        .o_busy      (busy),
        .o_done      (done),
        .o_nack      (nack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] tx_bytes[4];
    int         tx_len = 0;
    int         tx_idx = 0;
    int         ready_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         stop_cnt = 0;
    int         accept_cyc = 0;
    int         nack_at = -1;
    bit         stretch_armed = 1'b0;
    int         stretch_left = 0;
    logic [8:0] stat_q[$];
    int         stat_cyc[$];
    logic [7:0] bus_q[$];

    task automatic load_tx();
        if (tx_idx < tx_len) begin
            tx_valid = 1'b1;
            tx_data  = tx_bytes[tx_idx];
            tx_last  = (tx_idx == tx_len - 1);
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'd0;
            tx_last  = 1'b0;
        end
    endtask

    // Feeder: advance to the next byte only after the consuming clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin
                ready_cnt++;
                @(posedge clk);
                #1;
                tx_idx++;
                load_tx();
            end
        end
    end

    // Bus monitor and slave: decodes START/STOP, captures bytes, drives ACK and stretching.
    initial begin
        logic       prev_scl;
        logic       prev_sda;
        int         rc;
        int         byte_idx;
        logic [7:0] shbyte;
        prev_scl = 1'b0;
        prev_sda = 1'b0;
        rc       = 0;
        byte_idx = 0;
        shbyte   = 8'd0;
        forever begin
            @(negedge clk);
            if (stretch_left > 0) begin
                stretch_left--;
                if (stretch_left == 0) stretch_hold = 1'b0;
            end
            if (!prev_scl && !scl_oe && !prev_sda && sda_oe) begin
                rc       = 0;
                byte_idx = 0;
            end
            if (!prev_scl && !scl_oe && prev_sda && !sda_oe) stop_cnt++;
            if (prev_scl && !scl_oe) begin
                if (rc < 8) shbyte = {shbyte[6:0], sda_in};
                if (stretch_armed && byte_idx == 0 && rc == 2) begin
                    stretch_hold  = 1'b1;
                    stretch_left  = 50;
                    stretch_armed = 1'b0;
                end
                rc++;
            end
            if (!prev_scl && scl_oe) begin
                if (rc == 8) begin
                    ack_drive = (byte_idx != nack_at);
                end else if (rc == 9) begin
                    ack_drive = 1'b0;
                    bus_q.push_back(shbyte);
                    byte_idx++;
                    rc = 0;
                end
            end
            if (stat_valid === 1'b1) begin
                stat_q.push_back(stat_word);
                stat_cyc.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_scl = scl_oe;
            prev_sda = sda_oe;
        end
    end

    function automatic logic [8:0] stat_at(int i);
        return (i < stat_q.size()) ? stat_q[i] : 9'h1FF;
    endfunction

    function automatic logic [7:0] bus_at(int i);
        return (i < bus_q.size()) ? bus_q[i] : 8'hEE;
    endfunction

    function automatic int scyc_at(int i);
        return (i < stat_cyc.size()) ? stat_cyc[i] : -1;
    endfunction

    task automatic clear_state();
        stat_q.delete();
        stat_cyc.delete();
        bus_q.delete();
        ready_cnt     = 0;
        done_cnt      = 0;
        done_cyc      = 0;
        stop_cnt      = 0;
        nack_at       = -1;
        arb_pull      = 1'b0;
        stretch_armed = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [6:0] addr);
        @(posedge clk);
        #1;
        dev_addr = addr;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            if (done_cnt != 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({scl_oe, sda_oe, busy, done, nack, stat_valid, tx_ready, stat_word} !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h expected 0000",
                     {scl_oe, sda_oe, busy, done, nack, stat_valid, tx_ready, stat_word});
        end
        do_reset();
        checks++;
        if ({scl_oe, sda_oe, busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_idle: got %b expected 000", {scl_oe, sda_oe, busy});
        end
    endtask

    task automatic test_write_two_bytes();
        logic [8:0] exp_stat[3];
        logic [7:0] exp_bus[3];
        bit         ok;
        exp_stat = '{9'h094, 9'h020, 9'h0AA};
        exp_bus  = '{8'h94, 8'h10, 8'h55};
        clear_state();
        do_reset();
        tx_bytes[0] = 8'h10;
        tx_bytes[1] = 8'h55;
        tx_len = 2;
        tx_idx = 0;
        load_tx();
        checks++;
        if (sda_oe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pre_start_sda: got %b expected 0", sda_oe);
        end
        pulse_start(7'h4A);
        checks++;
        if ({sda_oe, scl_oe, busy} !== 3'b101) begin
            failures++;
            $display("[TB] FAIL start_latency: got %b expected 101", {sda_oe, scl_oe, busy});
        end
        wait_done(2000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL write_done_timeout: got no done expected done");
        end
        checks++;
        if (stat_q.size() !== 3) begin
            failures++;
            $display("[TB] FAIL write_stat_count: got %0d expected 3", stat_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stat_at(i) !== exp_stat[i]) begin
                failures++;
                $display("[TB] FAIL write_stat%0d: got %h expected %h", i, stat_at(i), exp_stat[i]);
            end
            checks++;
            if (bus_at(i) !== exp_bus[i]) begin
                failures++;
                $display("[TB] FAIL write_bus%0d: got %h expected %h", i, bus_at(i), exp_bus[i]);
            end
        end
        checks++;
        if ({ready_cnt, stop_cnt, done_cnt} !== {32'd2, 32'd1, 32'd1}) begin
            failures++;
            $display("[TB] FAIL write_counts: got ready=%0d stop=%0d done=%0d expected 2 1 1",
                     ready_cnt, stop_cnt, done_cnt);
        end
        checks++;
        if ({nack, busy} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL write_flags: got nack/busy=%b expected 00", {nack, busy});
        end
        checks++;
        if (scyc_at(0) - accept_cyc !== 160) begin
            failures++;
            $display("[TB] FAIL addr_latency: got %0d expected 160", scyc_at(0) - accept_cyc);
        end
        checks++;
        if (scyc_at(1) - scyc_at(0) !== 144) begin
            failures++;
            $display("[TB] FAIL byte_period: got %0d expected 144", scyc_at(1) - scyc_at(0));
        end
        checks++;
        if (done_cyc - accept_cyc !== 480) begin
            failures++;
            $display("[TB] FAIL write_done_time: got %0d expected 480", done_cyc - accept_cyc);
        end
    endtask

    task automatic test_nack_addr();
        bit ok;
        clear_state();
        do_reset();
        nack_at = 0;
        tx_bytes[0] = 8'h10;
        tx_bytes[1] = 8'h55;
        tx_len = 2;
        tx_idx = 0;
        load_tx();
        pulse_start(7'h4A);
        wait_done(2000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL nack_done_timeout: got no done expected done");
        end
        checks++;
        if (stat_q.size() !== 1 || stat_at(0) !== 9'h095) begin
            failures++;
            $display("[TB] FAIL nack_stat: got n=%0d w=%h expected n=1 w=095", stat_q.size(), stat_at(0));
        end
        checks++;
        if ({ready_cnt, stop_cnt, done_cnt} !== {32'd0, 32'd1, 32'd1}) begin
            failures++;
            $display("[TB] FAIL nack_counts: got ready=%0d stop=%0d done=%0d expected 0 1 1",
                     ready_cnt, stop_cnt, done_cnt);
        end
        checks++;
        if (nack !== 1'b1) begin
            failures++;
            $display("[TB] FAIL nack_flag: got %b expected 1", nack);
        end
        checks++;
        if (done_cyc - accept_cyc !== 192) begin
            failures++;
            $display("[TB] FAIL nack_done_time: got %0d expected 192", done_cyc - accept_cyc);
        end
    endtask

    task automatic test_underflow();
        bit ok;
        clear_state();
        do_reset();
        tx_len = 0;
        tx_idx = 0;
        load_tx();
        pulse_start(7'h4A);
        checks++;
        if (nack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nack_cleared_on_start: got %b expected 0", nack);
        end
        wait_done(2000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL underflow_done_timeout: got no done expected done");
        end
        checks++;
        if (stat_q.size() !== 1 || stat_at(0) !== 9'h094) begin
            failures++;
            $display("[TB] FAIL underflow_stat: got n=%0d w=%h expected n=1 w=094", stat_q.size(), stat_at(0));
        end
        checks++;
        if ({ready_cnt, stop_cnt, done_cnt, 31'd0, nack} !== {32'd0, 32'd1, 32'd1, 32'd0}) begin
            failures++;
            $display("[TB] FAIL underflow_counts: got ready=%0d stop=%0d done=%0d nack=%b expected 0 1 1 0",
                     ready_cnt, stop_cnt, done_cnt, nack);
        end
    endtask

    task automatic test_clock_stretch();
        bit ok;
        int exp_lat;
`ifdef CLOCK_STRETCH_EN
        exp_lat = 210;
`else
        exp_lat = 160;
`endif
        clear_state();
        do_reset();
        tx_len = 0;
        tx_idx = 0;
        load_tx();
        stretch_armed = 1'b1;
        pulse_start(7'h4A);
        wait_done(2000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL stretch_done_timeout: got no done expected done");
        end
        checks++;
        if (stat_at(0) !== 9'h094) begin
            failures++;
            $display("[TB] FAIL stretch_stat: got %h expected 094", stat_at(0));
        end
        checks++;
        if (scyc_at(0) - accept_cyc !== exp_lat) begin
            failures++;
            $display("[TB] FAIL stretch_latency: got %0d expected %0d", scyc_at(0) - accept_cyc, exp_lat);
        end
    endtask

    task automatic test_arbitration();
        bit ok;
        clear_state();
        do_reset();
        tx_len = 0;
        tx_idx = 0;
        load_tx();
        pulse_start(7'h4A);
        arb_pull = 1'b1;
        wait_done(2000, ok);
        arb_pull = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL arb_done_timeout: got no done expected done");
        end
        checks++;
        if ({stat_q.size(), stop_cnt, done_cnt} !== {32'd0, 32'd0, 32'd1}) begin
            failures++;
            $display("[TB] FAIL arb_counts: got stat=%0d stop=%0d done=%0d expected 0 0 1",
                     stat_q.size(), stop_cnt, done_cnt);
        end
        checks++;
        if (nack !== 1'b1) begin
            failures++;
            $display("[TB] FAIL arb_nack: got %b expected 1", nack);
        end
        checks++;
        if (done_cyc - accept_cyc !== 44) begin
            failures++;
            $display("[TB] FAIL arb_done_time: got %0d expected 44", done_cyc - accept_cyc);
        end
    endtask

    task automatic test_reset_mid_byte();
        clear_state();
        do_reset();
        tx_bytes[0] = 8'h00;
        tx_bytes[1] = 8'h00;
        tx_len = 2;
        tx_idx = 0;
        load_tx();
        pulse_start(7'h4A);
        repeat (213) @(negedge clk);
        checks++;
        if ({scl_oe, sda_oe, busy} !== 3'b111) begin
            failures++;
            $display("[TB] FAIL mid_byte_drive: got %b expected 111", {scl_oe, sda_oe, busy});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({scl_oe, sda_oe, busy, done} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL mid_reset_release: got %b expected 0000", {scl_oe, sda_oe, busy, done});
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        checks++;
        if ({done_cnt, stop_cnt, 31'd0, busy} !== {32'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("[TB] FAIL mid_reset_after: got done=%0d stop=%0d busy=%b expected 0 0 0",
                     done_cnt, stop_cnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_state();
        do_reset();
        tx_bytes[0] = 8'h3C;
        tx_len = 1;
        tx_idx = 0;
        load_tx();
        pulse_start(7'h4A);
        repeat (40) @(posedge clk);
        #1;
        dev_addr = 7'h11;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2000, ok);
        repeat (300) @(posedge clk);
        #1;
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL busy_start_timeout: got no done expected done");
        end
        checks++;
        if (stat_q.size() !== 2 || stat_at(0) !== 9'h094 || stat_at(1) !== 9'h078) begin
            failures++;
            $display("[TB] FAIL busy_start_stat: got n=%0d %h %h expected n=2 094 078",
                     stat_q.size(), stat_at(0), stat_at(1));
        end
        checks++;
        if (bus_at(0) !== 8'h94 || bus_at(1) !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL busy_start_bus: got %h %h expected 94 3c", bus_at(0), bus_at(1));
        end
        checks++;
        if ({done_cnt, ready_cnt, 30'd0, busy, nack} !== {32'd1, 32'd1, 32'd0}) begin
            failures++;
            $display("[TB] FAIL busy_start_counts: got done=%0d ready=%0d busy=%b nack=%b expected 1 1 0 0",
                     done_cnt, ready_cnt, busy, nack);
        end
    endtask

    initial begin
        test_reset();
        test_write_two_bytes();
        test_nack_addr();
        test_underflow();
        test_clock_stretch();
        test_arbitration();
        test_reset_mid_byte();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
